// File: rtl/led_matrix_column_scanner_if.sv
// Bus between the frame controller (master) and the column scanner (slave):
// scan index and shadow-write port in, column/row drive and status out.
interface led_matrix_column_scanner_if #(
  parameter int ROWS = 7
);
  logic [2:0]      scan_index;
  logic            wr_en;
  logic [2:0]      wr_col;
  logic [ROWS-1:0] wr_data;
  logic            commit;
  logic [4:0]      col_n;
  logic [ROWS-1:0] row_data;
  logic            frame_done;
  logic            pending;

  modport master (
    output scan_index, wr_en, wr_col, wr_data, commit,
    input  col_n, row_data, frame_done, pending
  );

  modport slave (
    input  scan_index, wr_en, wr_col, wr_data, commit,
    output col_n, row_data, frame_done, pending
  );
endinterface

// File: rtl/led_matrix_column_scanner.sv
// Double-buffered 5-column LED matrix scanner with tear-free swap at the 4->0
// frame boundary and all-off blanking after every column change.
module led_matrix_column_scanner #(
  parameter int ROWS         = 7,
  parameter int BLANK_CYCLES = 1
) (
  input logic                        clk,
  input logic                        rst_n,
  led_matrix_column_scanner_if.slave bus
);
  localparam int NCOLS = 5;
  localparam int CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  logic [ROWS-1:0]  shadow_q [NCOLS];
  logic [ROWS-1:0]  shadow_d [NCOLS];
  logic [ROWS-1:0]  active_q [NCOLS];
  logic [ROWS-1:0]  active_d [NCOLS];
  logic [2:0]       prev_index_q;
  logic [CNT_W-1:0] blank_cnt_q;
  logic [CNT_W-1:0] blank_cnt_d;
  logic [4:0]       col_n_q;
  logic [4:0]       col_n_d;
  logic [ROWS-1:0]  row_data_q;
  logic [ROWS-1:0]  row_data_d;
  logic             frame_done_q;
  logic             pending_q;
  logic             pending_d;

  logic             index_changed;
  logic             index_valid;
  logic             boundary;
  logic             blanking;
  logic             swap;

  always_comb begin
    shadow_d      = shadow_q;
    active_d      = active_q;
    pending_d     = pending_q;
    blank_cnt_d   = blank_cnt_q;
    col_n_d       = '1;
    row_data_d    = '0;
    blanking      = 1'b0;
    index_changed = (bus.scan_index != prev_index_q);
    index_valid   = (bus.scan_index < 3'd5);
    boundary      = (prev_index_q == 3'd4) && (bus.scan_index == 3'd0);
    swap          = boundary && (pending_q || bus.commit);

    // blank_cnt counts the all-off edges still owed after the change edge
    if (BLANK_CYCLES > 0) begin
      if (index_changed) begin
        blanking    = 1'b1;
        blank_cnt_d = CNT_W'(BLANK_CYCLES - 1);
      end else if (blank_cnt_q != '0) begin
        blanking    = 1'b1;
        blank_cnt_d = blank_cnt_q - 1'b1;
      end
    end

    if (!blanking && index_valid) begin
      col_n_d    = ~(5'b00001 << bus.scan_index);
      row_data_d = active_q[bus.scan_index];
    end

    // Swap copies the pre-write shadow; a same-edge write lands in shadow only
    if (swap) begin
      for (int c = 0; c < NCOLS; c++) begin
        active_d[c] = shadow_q[c];
      end
      pending_d = 1'b0;
    end else if (bus.commit) begin
      pending_d = 1'b1;
    end

    if (bus.wr_en && index_in_range(bus.wr_col)) begin
      shadow_d[bus.wr_col] = bus.wr_data;
    end
  end

  function automatic logic index_in_range(input logic [2:0] idx);
    return idx < 3'd5;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NCOLS; c++) begin
        shadow_q[c] <= '0;
        active_q[c] <= '0;
      end
      prev_index_q <= '0;
      blank_cnt_q  <= '0;
      col_n_q      <= '1;
      row_data_q   <= '0;
      frame_done_q <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      for (int c = 0; c < NCOLS; c++) begin
        shadow_q[c] <= shadow_d[c];
        active_q[c] <= active_d[c];
      end
      prev_index_q <= bus.scan_index;
      blank_cnt_q  <= blank_cnt_d;
      col_n_q      <= col_n_d;
      row_data_q   <= row_data_d;
      frame_done_q <= boundary;
      pending_q    <= pending_d;
    end
  end

  assign bus.col_n      = col_n_q;
  assign bus.row_data   = row_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;
endmodule

// File: tb/tb_led_matrix_column_scanner.sv
// Directed plus randomized bench for led_matrix_column_scanner against a
// history-based model of what the matrix should show after every edge.
module tb_led_matrix_column_scanner;
  localparam int ROWS  = 7;
  localparam int BLANK = 2;

  logic clk;
  logic rst_n;

  led_matrix_column_scanner_if #(.ROWS(ROWS)) bus ();

  led_matrix_column_scanner #(.ROWS(ROWS), .BLANK_CYCLES(BLANK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model: buffers, commit flag and the edge number of the last index change
  logic [ROWS-1:0] mShadow [5];
  logic [ROWS-1:0] mActive [5];
  bit              mPending;
  int              mPrev;
  int              mEdge;
  int              mLastChange;
  logic [4:0]      expCol;
  logic [ROWS-1:0] expRow;
  bit              expFd;

  task automatic modelEdge(input bit rst, input int idx, input bit we, input int col,
                           input int data, input bit cm);
    bit boundary;
    bit off;
    mEdge++;
    if (!rst) begin
      for (int c = 0; c < 5; c++) begin
        mShadow[c] = '0;
        mActive[c] = '0;
      end
      mPending    = 0;
      mPrev       = 0;
      mLastChange = -100;
      expCol      = 5'b11111;
      expRow      = '0;
      expFd       = 0;
    end else begin
      boundary = (mPrev == 4) && (idx == 0);
      if (idx != mPrev) mLastChange = mEdge;
      off = (idx > 4) || ((mEdge - mLastChange) < BLANK);
      if (off) begin
        expCol = 5'b11111;
        expRow = '0;
      end else begin
        expCol = 5'b11111;
        expCol[idx] = 1'b0;
        expRow = mActive[idx];
      end
      expFd = boundary;
      if (boundary && (mPending || cm)) begin
        for (int c = 0; c < 5; c++) mActive[c] = mShadow[c];
        mPending = 0;
      end else if (cm) begin
        mPending = 1;
      end
      if (we && col < 5) mShadow[col] = data[ROWS-1:0];
      mPrev = idx;
    end
  endtask

  task automatic applyStimulus(input bit rst, input int idx, input bit we = 0,
                               input int col = 0, input int data = 0, input bit cm = 0);
    rst_n          = rst;
    bus.scan_index = idx[2:0];
    bus.wr_en      = we;
    bus.wr_col     = col[2:0];
    bus.wr_data    = data[ROWS-1:0];
    bus.commit     = cm;
    @(posedge clk);
    modelEdge(rst, idx, we, col, data, cm);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_col_n"},      32'(bus.col_n),      32'(expCol));
    checkValue({tag, "_row_data"},   32'(bus.row_data),   32'(expRow));
    checkValue({tag, "_frame_done"}, 32'(bus.frame_done), 32'(expFd));
    checkValue({tag, "_pending"},    32'(bus.pending),    32'(mPending));
  endtask

  task automatic step(input string tag, input int idx, input bit we = 0, input int col = 0,
                      input int data = 0, input bit cm = 0);
    applyStimulus(1, idx, we, col, data, cm);
    checkOutput(tag);
  endtask

  initial begin
    int ri;
    int hold;
    mEdge = 0;
    mPending = 0;
    mPrev = 0;
    mLastChange = -100;

    // T1 reset with arbitrary inputs
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, $urandom_range(0, 7), 1, $urandom_range(0, 4), $urandom, 1);
      checkOutput("T1");
    end
    checkValue("T1_col_n", 32'(bus.col_n), 32'h1F);
    checkValue("T1_row", 32'(bus.row_data), 0);
    checkValue("T1_pending", 32'(bus.pending), 0);

    // T2 swap
    step("T2_w0", 0, 1, 0, 'h01);
    step("T2_w1", 0, 1, 1, 'h02);
    step("T2_w2", 0, 1, 2, 'h04);
    step("T2_w3", 0, 1, 3, 'h08);
    step("T2_w4", 0, 1, 4, 'h10);
    step("T2_i1", 1);
    step("T2_commit", 2, 0, 0, 0, 1);
    checkValue("T2_pending_set", 32'(bus.pending), 1);
    step("T2_i3", 3);
    checkValue("T2_i3_row", 32'(bus.row_data), 0);
    step("T2_i4", 4);
    step("T2_bnd", 0);
    checkValue("T2_frame_done", 32'(bus.frame_done), 1);
    checkValue("T2_pending_clr", 32'(bus.pending), 0);
    step("T2_blank", 0);
    step("T2_show0", 0);
    checkValue("T2_col0", 32'(bus.col_n), 32'h1E);
    checkValue("T2_row0", 32'(bus.row_data), 32'h01);
    for (int i = 0; i < 3; i++) step("T2_i3b", 3);
    checkValue("T2_col3", 32'(bus.col_n), 32'h17);
    checkValue("T2_row3", 32'(bus.row_data), 32'h08);

    // T3 blanking with reload
    for (int i = 0; i < 3; i++) step("T3_i1", 1);
    step("T3_N", 2);
    checkValue("T3_N_col", 32'(bus.col_n), 32'h1F);
    step("T3_N1", 3);
    step("T3_N2", 3);
    checkValue("T3_N2_col", 32'(bus.col_n), 32'h1F);
    step("T3_N3", 3);
    checkValue("T3_N3_col", 32'(bus.col_n), 32'h17);

    // T4 invalid index
    step("T4_i4c", 4, 0, 0, 0, 1);
    step("T4_i4", 4);
    step("T4_i6", 6);
    checkValue("T4_i6_col", 32'(bus.col_n), 32'h1F);
    step("T4_i6b", 6);
    checkValue("T4_i6_row", 32'(bus.row_data), 0);
    step("T4_i0", 0);
    checkValue("T4_no_fd", 32'(bus.frame_done), 0);
    checkValue("T4_pend_kept", 32'(bus.pending), 1);
    for (int i = 1; i <= 4; i++) step("T4_seq", i);
    step("T4_bnd", 0);

    // T5 write and swap on the same edge
    step("T5_w11", 0, 1, 0, 'h11);
    step("T5_i1", 1);
    step("T5_i2c", 2, 0, 0, 0, 1);
    step("T5_i3", 3);
    step("T5_i4", 4);
    step("T5_bnd", 0, 1, 0, 'h22);
    step("T5_b", 0);
    step("T5_show", 0);
    checkValue("T5_row_old", 32'(bus.row_data), 32'h11);
    step("T5_c5", 1, 1, 5, 'h7F, 1);
    step("T5_i2", 2);
    step("T5_i3b", 3);
    step("T5_i4b", 4);
    step("T5_bnd2", 0);
    step("T5_b2", 0);
    step("T5_show2", 0);
    checkValue("T5_row_new", 32'(bus.row_data), 32'h22);
    checkValue("T5_col_new", 32'(bus.col_n), 32'h1E);

    // T6 reset mid-frame
    step("T6_i1", 1);
    step("T6_i2", 2);
    step("T6_i3c", 3, 0, 0, 0, 1);
    checkValue("T6_pend", 32'(bus.pending), 1);
    applyStimulus(0, 3);
    checkOutput("T6_rst");
    checkValue("T6_pend_clr", 32'(bus.pending), 0);
    step("T6_i4", 4);
    step("T6_bnd", 0);
    checkValue("T6_fd", 32'(bus.frame_done), 1);
    step("T6_b", 0);
    step("T6_show", 0);
    checkValue("T6_row_zero", 32'(bus.row_data), 0);
    checkValue("T6_col", 32'(bus.col_n), 32'h1E);

    // Randomized scanning, writes, commits and occasional resets
    ri = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) ri = $urandom_range(0, 7);
      else ri = (ri >= 4) ? 0 : ri + 1;
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        applyStimulus(($urandom_range(0, 99) != 0), ri, ($urandom_range(0, 2) == 0),
                      $urandom_range(0, 6), $urandom, ($urandom_range(0, 9) == 0));
        checkOutput("RND");
      end
    end

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
